// File: rtl/psum_accum_relu_pkg.sv
// Shared widths for the partial-sum / write-back path.
// NUM_DATA_LEN and ACC_GUARD_BITS match the num_data.v macros so ACC_W stays consistent downstream.
`ifndef NUM_DATA_LEN
`define NUM_DATA_LEN 16
`endif
`ifndef ACC_GUARD_BITS
`define ACC_GUARD_BITS 4
`endif

package psum_accum_relu_pkg;
  localparam int DATA_LEN  = `NUM_DATA_LEN;
  localparam int ACC_GUARD = `ACC_GUARD_BITS;
  localparam int ACC_W     = DATA_LEN + ACC_GUARD;
endpackage

// File: rtl/psum_accum_relu_sat_relu.sv
// ReLU plus positive saturation of a signed accumulator down to a signed output width.
// Also used by the pooling/write-back stage.
module sat_relu
  import psum_accum_relu_pkg::*;
#(
  parameter int ACC_W_P = ACC_W,
  parameter int OUT_W   = DATA_LEN
) (
  input  logic signed [ACC_W_P-1:0] acc,
  output logic [OUT_W-1:0]          q
);

  // Largest positive value representable in OUT_W signed bits, at accumulator width.
  localparam logic signed [ACC_W_P-1:0] POS_MAX =
    {{(ACC_W_P-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  always_comb begin
    q = acc[OUT_W-1:0];
    if (acc[ACC_W_P-1]) begin
      q = '0;
    end else if (acc > POS_MAX) begin
      q = POS_MAX[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_accum_relu.sv
// Accumulates NUM_PHASE partial dot products, adds a bias, then ReLU/saturates
// the sum into a one-cycle result pulse for the feature-map write-back stage.
module psum_accum_relu
  import psum_accum_relu_pkg::*;
#(
  parameter int                          NUM_PHASE = 5,
  parameter logic signed [DATA_LEN-1:0]  BIAS      = '0,
  parameter int                          GUARD     = ACC_GUARD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] in_d,
  output logic                busy,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] q
);

  localparam int        AW         = DATA_LEN + GUARD;
  localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASE);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [3:0]             cnt_inc;
  logic                   in_valid_d;
  logic                   take;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   in_ext;
  logic signed [AW-1:0]   bias_ext;
  logic [DATA_LEN-1:0]    sat_q;

  // Upstream may hold in_valid for several cycles; only its rising edge is a new partial.
  assign take     = in_valid & ~in_valid_d;
  assign cnt_inc  = cnt + 4'd1;
  assign in_ext   = AW'($signed(in_d));
  assign bias_ext = AW'(BIAS);
  assign busy     = (state == ACCUM);

  sat_relu #(
    .ACC_W_P (AW),
    .OUT_W   (DATA_LEN)
  ) u_sat_relu (
    .acc (acc),
    .q   (sat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      state      <= IDLE;
      in_valid_d <= 1'b0;
      out_valid  <= 1'b0;
      q          <= '0;
    end else begin
      in_valid_d <= in_valid;
      out_valid  <= 1'b0;
      // clear wins over everything, including a partial arriving this cycle; q is kept.
      if (clear) begin
        acc   <= '0;
        cnt   <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (take) begin
              acc   <= in_ext;
              cnt   <= 4'd1;
              state <= (NUM_PHASE == 1) ? FINAL : ACCUM;
            end
          end
          ACCUM: begin
            if (take) begin
              acc <= acc + in_ext;
              cnt <= cnt_inc;
              if (cnt_inc == LAST_PHASE) begin
                state <= FINAL;
              end
            end
          end
          FINAL: begin
            acc   <= acc + bias_ext;
            state <= OUT;
          end
          OUT: begin
            q         <= sat_q;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_relu.sv
// Directed bench for psum_accum_relu: two instances (BIAS=0 and BIAS=3) share one stimulus stream.
module tb_psum_accum_relu;
  import psum_accum_relu_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                clear;
  logic                in_valid;
  logic [DATA_LEN-1:0] in_d;
  logic                busy0, ov0;
  logic [DATA_LEN-1:0] q0;
  logic                busy3, ov3;
  logic [DATA_LEN-1:0] q3;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses3 = 0;
  int double0 = 0;
  int double3 = 0;
  logic ov0_prev = 1'b0;
  logic ov3_prev = 1'b0;

  psum_accum_relu #(.NUM_PHASE(5), .BIAS(16'sd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_d(in_d),
    .busy(busy0), .out_valid(ov0), .q(q0)
  );

  psum_accum_relu #(.NUM_PHASE(5), .BIAS(16'sd3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_d(in_d),
    .busy(busy3), .out_valid(ov3), .q(q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping sampled on the inactive edge.
  always @(negedge clk) begin
    if (ov0) pulses0++;
    if (ov3) pulses3++;
    if (ov0 && ov0_prev) double0++;
    if (ov3 && ov3_prev) double3++;
    ov0_prev = ov0;
    ov3_prev = ov3;
  end

  // Called 1 time unit after a rising edge: 2 cycles high, 4 cycles low.
  task automatic send_partial(input logic [DATA_LEN-1:0] v);
    in_d     = v;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_d = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ov0); end
    checks++; if (q0 !== 16'd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", q0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) send_partial(16'd1);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL midacc_busy: got %b expected 1", busy0); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b/%b expected 0/0", busy0, busy3); end
    checks++; if (q0 !== 16'd0 || ov0 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_q: got q=%0d ov=%b expected q=0 ov=0", q0, ov0); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pulses0 = 0; pulses3 = 0;
    repeat (5) send_partial(16'd1);
    checks++; if (q0 !== 16'd5) begin errors++; $display("[TB] FAIL after_reset_sum_bias0: got %0d expected 5", q0); end
    checks++; if (q3 !== 16'd8) begin errors++; $display("[TB] FAIL after_reset_sum_bias3: got %0d expected 8", q3); end
    checks++; if (pulses0 !== 1) begin errors++; $display("[TB] FAIL after_reset_pulses: got %0d expected 1", pulses0); end
  endtask

  task automatic test_basic_sum;
    pulses0 = 0; pulses3 = 0;
    send_partial(16'd10);
    send_partial(-16'sd4);
    send_partial(16'd7);
    send_partial(16'd0);
    in_d = 16'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL take_cycle: got ov=%b busy=%b expected 0/0", ov0, busy0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got ov=%b expected 0", ov3); end
    @(posedge clk); #1;
    checks++; if (ov0 !== 1'b1 || q0 !== 16'd15) begin errors++; $display("[TB] FAIL basic_bias0: got ov=%b q=%0d expected ov=1 q=15", ov0, q0); end
    checks++; if (ov3 !== 1'b1 || q3 !== 16'd18) begin errors++; $display("[TB] FAIL basic_bias3: got ov=%b q=%0d expected ov=1 q=18", ov3, q3); end
    @(posedge clk); #1;
    checks++; if (ov3 !== 1'b0 || q3 !== 16'd18) begin errors++; $display("[TB] FAIL pulse_end: got ov=%b q=%0d expected ov=0 q=18", ov3, q3); end
    repeat (4) @(posedge clk); #1;
    checks++; if (pulses0 !== 1 || pulses3 !== 1) begin errors++; $display("[TB] FAIL basic_pulses: got %0d/%0d expected 1/1", pulses0, pulses3); end
  endtask

  task automatic test_relu;
    pulses0 = 0; pulses3 = 0;
    send_partial(-16'sd100);
    send_partial(16'd20);
    send_partial(16'd30);
    send_partial(16'd10);
    send_partial(16'd5);
    checks++; if (q0 !== 16'd0 || q3 !== 16'd0) begin errors++; $display("[TB] FAIL relu_q: got %0d/%0d expected 0/0", q0, q3); end
    checks++; if (pulses0 !== 1 || pulses3 !== 1) begin errors++; $display("[TB] FAIL relu_pulses: got %0d/%0d expected 1/1", pulses0, pulses3); end
  endtask

  task automatic test_saturation;
    repeat (5) send_partial(16'd30000);
    checks++; if (q0 !== 16'd32767 || q3 !== 16'd32767) begin errors++; $display("[TB] FAIL sat_pos: got %0d/%0d expected 32767/32767", q0, q3); end
    repeat (5) send_partial(-16'sd30000);
    checks++; if (q0 !== 16'd0 || q3 !== 16'd0) begin errors++; $display("[TB] FAIL sat_neg: got %0d/%0d expected 0/0", q0, q3); end
  endtask

  task automatic test_held_valid;
    pulses0 = 0; pulses3 = 0;
    in_d = 16'd7; in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (busy0 !== 1'b1 || busy3 !== 1'b1) begin errors++; $display("[TB] FAIL held_busy: got %b/%b expected 1/1", busy0, busy3); end
    repeat (4) @(posedge clk); #1;
    checks++; if (pulses0 !== 0) begin errors++; $display("[TB] FAIL held_no_pulse: got %0d expected 0", pulses0); end
    repeat (4) send_partial(16'd1);
    checks++; if (q0 !== 16'd11 || q3 !== 16'd14) begin errors++; $display("[TB] FAIL held_sum: got %0d/%0d expected 11/14", q0, q3); end
    checks++; if (pulses0 !== 1) begin errors++; $display("[TB] FAIL held_pulses: got %0d expected 1", pulses0); end
  endtask

  task automatic test_clear;
    pulses0 = 0; pulses3 = 0;
    send_partial(16'd5);
    send_partial(16'd5);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL clear_pre_busy: got %b expected 1", busy0); end
    in_d = 16'd5; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (busy0 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_state: got busy=%b ov=%b expected 0/0", busy0, ov0); end
    checks++; if (q0 !== 16'd11 || q3 !== 16'd14) begin errors++; $display("[TB] FAIL clear_q_kept: got %0d/%0d expected 11/14", q0, q3); end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_discard: got busy=%b expected 0", busy0); end
    repeat (5) send_partial(16'd2);
    checks++; if (q0 !== 16'd10 || q3 !== 16'd13) begin errors++; $display("[TB] FAIL clear_resum: got %0d/%0d expected 10/13", q0, q3); end
    checks++; if (pulses0 !== 1 || pulses3 !== 1) begin errors++; $display("[TB] FAIL clear_pulses: got %0d/%0d expected 1/1", pulses0, pulses3); end
  endtask

  task automatic test_pulse_width;
    checks++; if (double0 !== 0 || double3 !== 0) begin errors++; $display("[TB] FAIL pulse_width: got %0d/%0d back-to-back pulses expected 0/0", double0, double3); end
  endtask

  initial begin
    $display("[TB] starting psum_accum_relu bench");
    test_reset();
    test_basic_sum();
    test_relu();
    test_saturation();
    test_held_valid();
    test_clear();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
